// File: rtl/tpu_psum_writeback_if.sv
// rtl/tpu_psum_writeback_if.sv - buffer P access port between drain stage and global buffer
interface tpu_psum_writeback_if #(
    parameter int ARRAY_DIM  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                            enp_o;
    logic                            wep_o;
    logic [ADDR_WIDTH-1:0]           addrp_o;
    logic [ARRAY_DIM*DATA_WIDTH-1:0] wordp_o;
    logic [ARRAY_DIM*DATA_WIDTH-1:0] wordp_i;

    modport master (output enp_o, output wep_o, output addrp_o, output wordp_o, input wordp_i);
    modport slave  (input enp_o, input wep_o, input addrp_o, input wordp_o, output wordp_i);
endinterface

// File: rtl/tpu_psum_writeback.sv
// rtl/tpu_psum_writeback.sv - snapshot PE column results and drain them to buffer P
// Overwrite or read-modify-write accumulate with per-lane mask and signed saturation.
module tpu_psum_writeback #(
    parameter int ARRAY_DIM  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      start_i,
    input  logic                                      acc_i,
    input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0] cols_i,
    input  logic [ADDR_WIDTH-1:0]                     rows_i,
    input  logic [ARRAY_DIM-1:0]                      lane_mask_i,
    input  logic [ADDR_WIDTH-1:0]                     base_addrp_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      sat_o,
    tpu_psum_writeback_if.master                      p_bus
);
    localparam int WW = ARRAY_DIM * DATA_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam int RW = CW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                     r_state;
    logic [ARRAY_DIM*WW-1:0]        r_cols;
    logic                           r_acc;
    logic [ARRAY_DIM-1:0]           r_mask;
    logic [ADDR_WIDTH-1:0]          r_base;
    logic [RW-1:0]                  r_rows;
    logic [CW-1:0]                  r_col_idx;
    logic                           r_sat;

    logic [RW-1:0]                  w_rows_clamped;
    logic [WW-1:0]                  w_col;
    logic [ADDR_WIDTH-1:0]          w_addr;
    logic                           w_last;
    logic                           w_active;
    logic [WW-1:0]                  w_wdata;
    logic [ARRAY_DIM-1:0]           w_sat_lane;

    assign w_rows_clamped = (rows_i > ADDR_WIDTH'(ARRAY_DIM)) ? RW'(ARRAY_DIM) : rows_i[RW-1:0];
    assign w_col          = r_cols[r_col_idx*WW +: WW];
    assign w_addr         = r_base + ADDR_WIDTH'(r_col_idx);
    assign w_last         = ({1'b0, r_col_idx} == (r_rows - RW'(1)));
    assign w_active       = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_ACC);

    // Per-lane write data; the one-bit-wider sum exposes signed overflow in its top two bits.
    for (genvar l = 0; l < ARRAY_DIM; l++) begin : g_lane
        logic [DW-1:0] w_src;
        logic [DW-1:0] w_old;
        logic [DW:0]   w_sum;
        logic          w_ovf;
        logic [DW-1:0] w_accv;

        assign w_src  = w_col[l*DW +: DW];
        assign w_old  = p_bus.wordp_i[l*DW +: DW];
        assign w_sum  = {w_old[DW-1], w_old} + {w_src[DW-1], w_src};
        assign w_ovf  = w_sum[DW] ^ w_sum[DW-1];
        assign w_accv = w_ovf ? (w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                              : w_sum[DW-1:0];
        assign w_sat_lane[l] = r_mask[l] & w_ovf;
        assign w_wdata[l*DW +: DW] =
            (r_state == S_WR)  ? (r_mask[l] ? w_src  : '0)    :
            (r_state == S_ACC) ? (r_mask[l] ? w_accv : w_old) : '0;
    end

    assign p_bus.enp_o   = w_active;
    assign p_bus.wep_o   = (r_state == S_WR) || (r_state == S_ACC);
    assign p_bus.addrp_o = w_active ? w_addr : '0;
    assign p_bus.wordp_o = w_wdata;
    assign busy_o        = w_active;
    assign done_o        = (r_state == S_DONE);
    assign sat_o         = r_sat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cols    <= '0;
            r_acc     <= 1'b0;
            r_mask    <= '0;
            r_base    <= '0;
            r_rows    <= '0;
            r_col_idx <= '0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cols    <= cols_i;
                        r_acc     <= acc_i;
                        r_mask    <= lane_mask_i;
                        r_base    <= base_addrp_i;
                        r_rows    <= w_rows_clamped;
                        r_col_idx <= '0;
                        r_sat     <= 1'b0;
                        if (w_rows_clamped == '0) r_state <= S_DONE;
                        else                      r_state <= acc_i ? S_RD : S_WR;
                    end
                end
                S_WR: begin
                    if (w_last) r_state <= S_DONE;
                    else        r_col_idx <= r_col_idx + CW'(1);
                end
                S_RD: r_state <= S_ACC;
                S_ACC: begin
                    if (|w_sat_lane) r_sat <= 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state   <= S_RD;
                        r_col_idx <= r_col_idx + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_psum_writeback.sv
// tb/tb_tpu_psum_writeback.sv - scoreboard bench for tpu_psum_writeback
module tb_tpu_psum_writeback;
    localparam int DIM = 8;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int WW  = DIM * DW;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic               clk = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic               acc_i;
    logic [DIM*WW-1:0]  cols_i;
    logic [AW-1:0]      rows_i;
    logic [DIM-1:0]     lane_mask_i;
    logic [AW-1:0]      base_addrp_i;
    logic               busy_o;
    logic               done_o;
    logic               sat_o;

    tpu_psum_writeback_if #(.ARRAY_DIM(DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) pif ();

    tpu_psum_writeback #(.ARRAY_DIM(DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .acc_i        (acc_i),
        .cols_i       (cols_i),
        .rows_i       (rows_i),
        .lane_mask_i  (lane_mask_i),
        .base_addrp_i (base_addrp_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sat_o        (sat_o),
        .p_bus        (pif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer P: one-cycle read latency, plus a bench-side preload port.
    logic [WW-1:0] pmem [0:65535];
    logic [WW-1:0] refm [0:65535];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_wa = '0;
    logic [WW-1:0] tb_wd = '0;

    always @(posedge clk) begin
        if (tb_we) pmem[tb_wa] <= tb_wd;
        else if (pif.enp_o && pif.wep_o) pmem[pif.addrp_o] <= pif.wordp_o;
        if (pif.enp_o && !pif.wep_o) pif.wordp_i <= pmem[pif.addrp_o];
    end

    typedef struct { bit wr; logic [AW-1:0] addr; logic [WW-1:0] data; int cyc; } ev_t;
    typedef struct { int cyc; bit sat; } dn_t;
    ev_t evq[$];
    dn_t dnq[$];

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    task automatic chk(string nm, logic [WW-1:0] act, logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        dn_t d;
        if (mon_en) begin
            if (pif.enp_o) begin
                if (evq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_access actual addr=%0h cycle=%0d required=no access", pif.addrp_o, cyc);
                end else begin
                    e = evq.pop_front();
                    chk("access_cycle", cyc, e.cyc);
                    chk("access_wep", pif.wep_o, e.wr);
                    chk("access_addr", pif.addrp_o, e.addr);
                    chk("busy_in_drain", busy_o, 1);
                    if (e.wr) chk("write_data", pif.wordp_o, e.data);
                    else      chk("read_wordp_zero", pif.wordp_o, 0);
                end
            end
            if (done_o) begin
                if (dnq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual cycle=%0d required=no done", cyc);
                end else begin
                    d = dnq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("done_sat", sat_o, d.sat);
                    chk("done_busy_low", busy_o, 0);
                end
            end
        end
    end

    function automatic logic [WW-1:0] rword();
        logic [WW-1:0] r;
        for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: new word from old word and column word, lane by lane in plain integers.
    function automatic logic [WW-1:0] upd(bit acc, logic [DIM-1:0] mask, logic [WW-1:0] oldw,
                                          logic [WW-1:0] colw, output bit sat);
        logic [WW-1:0] res;
        int o, s, v;
        sat = 1'b0;
        for (int l = 0; l < DIM; l++) begin
            o = int'($signed(oldw[l*DW +: DW]));
            s = int'($signed(colw[l*DW +: DW]));
            if (!acc)          v = mask[l] ? s : 0;
            else if (!mask[l]) v = o;
            else begin
                v = o + s;
                if (v > MAXV) begin v = MAXV; sat = 1'b1; end
                if (v < MINV) begin v = MINV; sat = 1'b1; end
            end
            res[l*DW +: DW] = DW'(v);
        end
        return res;
    endfunction

    task automatic preload(logic [AW-1:0] a, logic [WW-1:0] w);
        refm[a] = w;
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = w;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // abort >= 0: hold rst_i during relative cycle 'abort'.
    task automatic issue(bit acc, logic [DIM-1:0] mask, logic [AW-1:0] base, logic [AW-1:0] rows,
                         logic [DIM*WW-1:0] cols, int abort, bit disturb);
        int r, s, lim, dc;
        logic [AW-1:0] a;
        logic [WW-1:0] nw;
        bit sl, sat;
        ev_t e;
        dn_t d;
        r = (rows > AW'(DIM)) ? DIM : int'(rows);
        sat = 1'b0;
        @(posedge clk); #1;
        s = cyc;
        lim = (abort < 0) ? s + 1000 : s + abort;
        start_i = 1'b1; acc_i = acc; lane_mask_i = mask; base_addrp_i = base;
        rows_i = rows; cols_i = cols;
        for (int c = 0; c < r; c++) begin
            a = base + AW'(c);
            nw = upd(acc, mask, refm[a], cols[c*WW +: WW], sl);
            if (acc && (s + 1 + 2*c) <= lim) begin
                e.wr = 1'b0; e.addr = a; e.data = '0; e.cyc = s + 1 + 2*c;
                evq.push_back(e);
            end
            e.cyc = acc ? s + 2 + 2*c : s + 1 + c;
            if (e.cyc <= lim) begin
                e.wr = 1'b1; e.addr = a; e.data = nw;
                evq.push_back(e);
                refm[a] = nw;
                sat |= sl;
            end
        end
        dc = (r == 0) ? s + 1 : (acc ? s + 2*r + 1 : s + r + 1);
        if (dc <= lim) begin
            d.cyc = dc; d.sat = sat;
            dnq.push_back(d);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        cols_i = {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()};
        if (disturb && r >= 1) begin
            start_i = 1'b1; acc_i = ~acc; lane_mask_i = DIM'($urandom);
            base_addrp_i = AW'($urandom); rows_i = AW'($urandom_range(1, 8));
            @(posedge clk); #1;
            start_i = 1'b0;
            cols_i = {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()};
        end
        if (abort >= 0) begin
            for (int k = 0; k < 64 && cyc < s + abort; k++) begin @(posedge clk); #1; end
            rst_i = 1'b1;
            @(posedge clk); #1;
            rst_i = 1'b0;
            @(negedge clk);
            chk("reset_enp_off", pif.enp_o, 0);
            chk("reset_busy_off", busy_o, 0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k < 64 && cyc < dc + 2; k++) begin @(posedge clk); #1; end
        end
        chk("queue_drained", evq.size() + dnq.size(), 0);
        evq.delete();
        dnq.delete();
    endtask

    logic [DIM*WW-1:0] cw;
    logic [WW-1:0]     w;
    bit                acc_r;
    logic [AW-1:0]     base_r, rows_r;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; acc_i = 1'b0; cols_i = '0; rows_i = '0;
        lane_mask_i = '0; base_addrp_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_sat", sat_o, 0);
        chk("reset_enp", pif.enp_o, 0);
        chk("reset_wep", pif.wep_o, 0);
        chk("reset_addrp", pif.addrp_o, 0);
        chk("reset_wordp", pif.wordp_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Overwrite with col[c][l] = c*8+l
        for (int c = 0; c < DIM; c++)
            for (int l = 0; l < DIM; l++) cw[c*WW + l*DW +: DW] = DW'(c * 8 + l);
        issue(1'b0, 8'hFF, 16'h0010, 16'd8, cw, -1, 1'b0);

        // Lane mask
        issue(1'b0, 8'h0F, 16'h0040, 16'd2, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b0);

        // Saturation both directions
        for (int l = 0; l < DIM; l++) begin
            w[l*DW +: DW]  = (l % 2 == 0) ? 16'h7FF0 : 16'h8005;
            cw[l*DW +: DW] = (l % 2 == 0) ? 16'h0100 : 16'hFF00;
        end
        preload(16'h0030, w);
        issue(1'b1, 8'hFF, 16'h0030, 16'd1, cw, -1, 1'b0);
        chk("sat_sticky_after_drain", sat_o, 1);

        // Simple accumulate: 100 + 23
        for (int l = 0; l < DIM; l++) begin
            w[l*DW +: DW]  = 16'd100;
            cw[l*DW +: DW] = 16'd23;
        end
        preload(16'h0020, w);
        issue(1'b1, 8'hFF, 16'h0020, 16'd1, cw, -1, 1'b0);

        // Address wrap, R=0, R clamp
        issue(1'b0, 8'hFF, 16'hFFFF, 16'd3, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b0);
        for (int c = 0; c < 3; c++) preload(16'hFFFE + AW'(c), rword());
        issue(1'b1, 8'hA5, 16'hFFFE, 16'd3, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b0);
        issue(1'b1, 8'hFF, 16'h0100, 16'd0, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b0);
        issue(1'b0, 8'hFF, 16'h0200, 16'd20, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b0);

        // Start while busy, and reset mid-drain
        issue(1'b0, 8'hFF, 16'h0300, 16'd8, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b1);
        for (int c = 0; c < 4; c++) preload(16'h0400 + AW'(c), rword());
        issue(1'b1, 8'h3C, 16'h0400, 16'd4, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, -1, 1'b1);
        issue(1'b0, 8'hFF, 16'h0500, 16'd8, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, 3, 1'b0);
        for (int c = 0; c < 4; c++) preload(16'h0600 + AW'(c), rword());
        issue(1'b1, 8'hFF, 16'h0600, 16'd4, {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()}, 3, 1'b0);

        // Randomised drains
        for (int it = 0; it < 40; it++) begin
            acc_r  = 1'($urandom);
            base_r = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFF - $urandom_range(0, 5)) : AW'($urandom);
            rows_r = AW'($urandom_range(0, 10));
            for (int c = 0; c < DIM; c++) preload(base_r + AW'(c), rword());
            issue(acc_r, DIM'($urandom), base_r, rows_r,
                  {rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword()},
                  -1, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
